// File: rtl/servo_pwm_decoder.sv
// servo_pwm_decoder
//   Decodes a hobby-servo PWM stream into a direction bit and a 7-bit
//   magnitude relative to the neutral pulse width. The raw pin is resynchronised.
//   Pulse width and rise-to-rise period are measured in clk cycles. Each pulse
//   is either accepted (valid strobe) or rejected (error strobe).
//
// Ports
//   clk        system clock, all logic on posedge
//   rst        synchronous active-high reset
//   pwm_in     asynchronous servo PWM line
//   direction  1 = right of neutral, 0 = left or neutral
//   position   magnitude in steps of 2^SHIFT cycles, 0 = neutral
//   valid      one-cycle strobe: direction/position updated from a pulse
//   error      one-cycle strobe: pulse or frame rejected
//   locked     level: two or more consecutive healthy pulses seen
//
// WIDTH_BITS / PERIOD_BITS size the width and period counters. They only need
// changing for scaled-down simulation.
module servo_pwm_decoder #(
  parameter int CLK_FREQ      = 50_000_000,
  parameter int NEUTRAL_COUNT = CLK_FREQ / 667,
  parameter int SHIFT         = 8,
  parameter int MIN_PERIOD    = CLK_FREQ / 100,
  parameter int TIMEOUT       = CLK_FREQ / 25,
  parameter int WIDTH_BITS    = 17,
  parameter int PERIOD_BITS   = 21
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pwm_in,
  output logic       direction,
  output logic [6:0] position,
  output logic       valid,
  output logic       error,
  output logic       locked
);

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    HIGH = 2'd2
  } state_t;

  localparam logic [WIDTH_BITS-1:0]  WIDTH_MAX  = '1;
  localparam logic [PERIOD_BITS-1:0] PERIOD_MAX = '1;
  localparam logic [PERIOD_BITS-1:0] MIN_P      = PERIOD_BITS'(MIN_PERIOD);
  localparam logic [PERIOD_BITS-1:0] TIMEOUT_P  = PERIOD_BITS'(TIMEOUT);

  // Accepted width window: neutral +/- 128 position steps.
  localparam int          SPAN     = 1 << (SHIFT + 7);
  localparam int          LO_RAW   = NEUTRAL_COUNT - SPAN;
  localparam logic [31:0] WIDTH_LO = (LO_RAW < 0) ? 32'd0 : 32'(LO_RAW);
  localparam logic [31:0] WIDTH_HI = 32'(NEUTRAL_COUNT + SPAN);
  localparam logic [31:0] NEUTRAL  = 32'(NEUTRAL_COUNT);
  localparam logic [31:0] ROUND    = 32'(1 << (SHIFT - 1));

  // Synchroniser and edge history
  logic sync_q1_reg;
  logic s_in_reg;
  logic s_prev_reg;

  // Counts clocks since reset release so INIT only trusts s_in once it holds
  // a real pin sample rather than the reset value.
  logic [1:0] settle_reg, settle_next;

  state_t                 state_reg, state_next;
  logic [WIDTH_BITS-1:0]  width_reg, width_next;
  logic [PERIOD_BITS-1:0] period_reg, period_next;
  logic                   direction_reg, direction_next;
  logic [6:0]             position_reg, position_next;
  logic                   valid_reg, valid_next;
  logic                   error_reg, error_next;
  logic                   locked_reg, locked_next;
  logic [1:0]             good_cnt_reg, good_cnt_next;

  logic rise, fall;
  assign rise = s_in_reg & ~s_prev_reg;
  assign fall = ~s_in_reg & s_prev_reg;

  // Width-to-position conversion, evaluated against the finished width.
  logic [31:0] width_ext;
  logic [31:0] diff;
  logic [31:0] pos_full;
  logic        conv_dir;
  logic        conv_ok;

  always_comb begin
    width_ext = 32'(width_reg);
    if (width_ext >= NEUTRAL) begin
      diff     = width_ext - NEUTRAL;
      conv_dir = 1'b1;
    end else begin
      diff     = NEUTRAL - width_ext;
      conv_dir = 1'b0;
    end
    pos_full = (diff + ROUND) >> SHIFT;
    // A width that rounds to neutral reports no direction.
    if (pos_full == 32'd0) begin
      conv_dir = 1'b0;
    end
    conv_ok = (width_ext >= WIDTH_LO) && (width_ext <= WIDTH_HI) &&
              (pos_full <= 32'd127);
  end

  logic timeout_hit;

  always_comb begin
    state_next     = state_reg;
    width_next     = width_reg;
    period_next    = period_reg;
    direction_next = direction_reg;
    position_next  = position_reg;
    valid_next     = 1'b0;
    error_next     = 1'b0;
    locked_next    = locked_reg;
    good_cnt_next  = good_cnt_reg;
    settle_next    = (settle_reg == 2'd2) ? 2'd2 : settle_reg + 2'd1;
    timeout_hit    = 1'b0;

    // The period counter stops once it reaches TIMEOUT, so the timeout event
    // fires exactly once per silent stretch.
    if ((period_reg < TIMEOUT_P) && (period_reg != PERIOD_MAX)) begin
      period_next = period_reg + PERIOD_BITS'(1);
      if (period_next == TIMEOUT_P) begin
        timeout_hit = 1'b1;
      end
    end

    if (timeout_hit) begin
      locked_next    = 1'b0;
      good_cnt_next  = 2'd0;
      direction_next = 1'b0;
      position_next  = 7'd0;
    end

    case (state_reg)
      INIT: begin
        if (!s_in_reg && (settle_reg == 2'd2)) begin
          state_next = IDLE;
        end
      end

      IDLE: begin
        if (rise) begin
          state_next  = HIGH;
          width_next  = WIDTH_BITS'(1);  // the rise cycle is the first high cycle
          period_next = '0;
          // An early frame is flagged, but the pulse itself is still measured.
          if (locked_reg && (period_reg < MIN_P)) begin
            error_next    = 1'b1;
            locked_next   = 1'b0;
            good_cnt_next = 2'd0;
          end
        end
      end

      HIGH: begin
        if (fall) begin
          state_next = IDLE;
          if (conv_ok) begin
            direction_next = conv_dir;
            position_next  = pos_full[6:0];
            valid_next     = 1'b1;
            if (good_cnt_next != 2'd2) begin
              good_cnt_next = good_cnt_next + 2'd1;
            end
            locked_next = (good_cnt_next == 2'd2);
          end else begin
            error_next    = 1'b1;
            locked_next   = 1'b0;
            good_cnt_next = 2'd0;
          end
        end else if (s_in_reg) begin
          if (width_reg == WIDTH_MAX) begin
            // Stuck high: report once and wait for the line to go low.
            state_next    = INIT;
            error_next    = 1'b1;
            locked_next   = 1'b0;
            good_cnt_next = 2'd0;
          end else begin
            width_next = width_reg + WIDTH_BITS'(1);
          end
        end
      end

      default: begin
        state_next = INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1_reg   <= 1'b0;
      s_in_reg      <= 1'b0;
      s_prev_reg    <= 1'b0;
      settle_reg    <= 2'd0;
      state_reg     <= INIT;
      width_reg     <= '0;
      period_reg    <= '0;
      direction_reg <= 1'b0;
      position_reg  <= 7'd0;
      valid_reg     <= 1'b0;
      error_reg     <= 1'b0;
      locked_reg    <= 1'b0;
      good_cnt_reg  <= 2'd0;
    end else begin
      sync_q1_reg   <= pwm_in;
      s_in_reg      <= sync_q1_reg;
      s_prev_reg    <= s_in_reg;
      settle_reg    <= settle_next;
      state_reg     <= state_next;
      width_reg     <= width_next;
      period_reg    <= period_next;
      direction_reg <= direction_next;
      position_reg  <= position_next;
      valid_reg     <= valid_next;
      error_reg     <= error_next;
      locked_reg    <= locked_next;
      good_cnt_reg  <= good_cnt_next;
    end
  end

  assign direction = direction_reg;
  assign position  = position_reg;
  assign valid     = valid_reg;
  assign error     = error_reg;
  assign locked    = locked_reg;

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Bench for servo_pwm_decoder with scaled-down timing so the run stays short.
// Frames are described as (high cycles, low cycles). A high-level model
// predicts the strobes, outputs and lock state of every frame.
module tb_servo_pwm_decoder;
  localparam int N0   = 300;
  localparam int SH   = 1;
  localparam int MINP = 800;
  localparam int TOUT = 2500;
  localparam int WB   = 10;
  localparam int SPAN = 1 << (SH + 7);
  localparam int WSAT = (1 << WB) - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pwm_in = 1'b0;
  logic       direction;
  logic [6:0] position;
  logic       valid;
  logic       error;
  logic       locked;

  servo_pwm_decoder #(
    .CLK_FREQ(200_000), .NEUTRAL_COUNT(N0), .SHIFT(SH), .MIN_PERIOD(MINP),
    .TIMEOUT(TOUT), .WIDTH_BITS(WB), .PERIOD_BITS(21)
  ) dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in), .direction(direction),
    .position(position), .valid(valid), .error(error), .locked(locked)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Strobe monitor
  int valid_seen = 0, err_seen = 0, both_seen = 0, last_valid_cyc = 0;
  always @(negedge clk) begin
    if (valid) begin
      valid_seen++;
      last_valid_cyc = cyc;
    end
    if (error) err_seen++;
    if (valid && error) both_seen++;
  end

  int assert_cnt = 0, fail_cnt = 0;

  // Model state
  bit m_dir = 0;
  int m_pos = 0, m_cnt = 0, prev_len = 0;
  // Per-frame expectations and observations
  bit ev, ed, el;
  int ee, obs_v, obs_e, lat;

  task automatic model_reset();
    m_dir = 0; m_pos = 0; m_cnt = 0; prev_len = 0;
  endtask

  // Drives one frame (starting at a negedge) and predicts its outcome.
  task automatic run_frame(input int n, input int l);
    int v0, e0, diff, p, fall_cyc;
    v0 = valid_seen; e0 = err_seen; ev = 0; ee = 0;
    if (m_cnt >= 2 && prev_len > 0 && prev_len < MINP) begin
      ee++; m_cnt = 0;
    end
    diff = (n >= N0) ? n - N0 : N0 - n;
    p = (diff + (1 << (SH - 1))) >> SH;
    if (n > WSAT) begin
      ee++; m_cnt = 0;
    end else if (n >= N0 - SPAN && n <= N0 + SPAN && p <= 127) begin
      ev = 1; m_pos = p; m_dir = (n > N0) && (p != 0); m_cnt++;
    end else begin
      ee++; m_cnt = 0;
    end
    if (n + l > TOUT) begin
      m_cnt = 0; m_dir = 0; m_pos = 0;
    end
    prev_len = n + l;
    pwm_in = 1'b1;
    repeat (n) @(negedge clk);
    pwm_in = 1'b0;
    fall_cyc = cyc;
    repeat (l) @(negedge clk);
    obs_v = valid_seen - v0;
    obs_e = err_seen - e0;
    lat = last_valid_cyc - fall_cyc;
    ed = m_dir;
    el = (m_cnt >= 2);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    assert_cnt++;
    if ({direction, position, valid, error, locked} !== 11'd0) begin
      fail_cnt++;
      $display("FAIL reset_state: got dir=%0b pos=%0d valid=%0b err=%0b lock=%0b, want all 0",
               direction, position, valid, error, locked);
    end
    rst = 1'b0;
    repeat (10) @(negedge clk);
    assert_cnt++;
    if (valid_seen !== 0 || err_seen !== 0) begin
      fail_cnt++;
      $display("FAIL reset_quiet: got valid=%0d err=%0d strobes, want 0", valid_seen, err_seen);
    end
    model_reset();
  endtask

  task automatic test_neutral_lock();
    for (int i = 0; i < 2; i++) begin
      run_frame(300, 700);
      assert_cnt++;
      if (obs_v !== 1 || obs_e !== 0 || lat < 1 || lat > 4) begin
        fail_cnt++;
        $display("FAIL neutral_strobe[%0d]: got valid=%0d err=%0d lat=%0d, want 1 0 <=4", i, obs_v, obs_e, lat);
      end
      assert_cnt++;
      if (direction !== 1'b0 || position !== 7'd0 || locked !== (i == 1)) begin
        fail_cnt++;
        $display("FAIL neutral_out[%0d]: got dir=%0b pos=%0d lock=%0b, want 0 0 %0b", i, direction, position, locked, i == 1);
      end
    end
  endtask

  task automatic test_boundaries();
    int widths[13] = '{380, 46, 45, 554, 555, 300, 301, 299, 44, 556, 557, 43, 420};
    foreach (widths[i]) begin
      run_frame(widths[i], 1000 - widths[i]);
      assert_cnt++;
      if (obs_v !== int'(ev) || obs_e !== ee || (ev && (lat < 1 || lat > 4))) begin
        fail_cnt++;
        $display("FAIL boundary_strobe w=%0d: got valid=%0d err=%0d lat=%0d, want valid=%0d err=%0d",
                 widths[i], obs_v, obs_e, lat, ev, ee);
      end
      assert_cnt++;
      if (direction !== ed || position !== 7'(m_pos) || locked !== el) begin
        fail_cnt++;
        $display("FAIL boundary_out w=%0d: got dir=%0b pos=%0d lock=%0b, want %0b %0d %0b",
                 widths[i], direction, position, locked, ed, m_pos, el);
      end
    end
  endtask

  task automatic test_random();
    int n;
    for (int i = 0; i < 16; i++) begin
      n = $urandom_range(620, 20);
      run_frame(n, 1000 - n);
      assert_cnt++;
      if (obs_v !== int'(ev) || obs_e !== ee) begin
        fail_cnt++;
        $display("FAIL random_strobe w=%0d: got valid=%0d err=%0d, want %0d %0d", n, obs_v, obs_e, ev, ee);
      end
      assert_cnt++;
      if (direction !== ed || position !== 7'(m_pos) || locked !== el) begin
        fail_cnt++;
        $display("FAIL random_out w=%0d: got dir=%0b pos=%0d lock=%0b, want %0b %0d %0b",
                 n, direction, position, locked, ed, m_pos, el);
      end
    end
    assert_cnt++;
    if (both_seen !== 0) begin
      fail_cnt++;
      $display("FAIL strobe_exclusive: got %0d cycles with valid and error, want 0", both_seen);
    end
  endtask

  task automatic test_early_rise();
    int hi[5] = '{300, 340, 340, 360, 360};
    int lo[5] = '{700, 700, 60, 640, 640};
    for (int i = 0; i < 5; i++) begin
      run_frame(hi[i], lo[i]);
      assert_cnt++;
      if (obs_v !== int'(ev) || obs_e !== ee || direction !== ed || position !== 7'(m_pos) || locked !== el) begin
        fail_cnt++;
        $display("FAIL early_rise[%0d]: got v=%0d e=%0d dir=%0b pos=%0d lock=%0b, want %0d %0d %0b %0d %0b",
                 i, obs_v, obs_e, direction, position, locked, ev, ee, ed, m_pos, el);
      end
    end
  endtask

  // Frames with a bad last pulse: (stimulus list, high of last frame)
  task automatic test_bad_pulse(input int bad_n, input string name);
    int hi[3];
    hi = '{380, 380, bad_n};
    for (int i = 0; i < 3; i++) begin
      run_frame(hi[i], (i == 2) ? 400 : 620);
      assert_cnt++;
      if (obs_v !== int'(ev) || obs_e !== ee || direction !== ed || position !== 7'(m_pos) || locked !== el) begin
        fail_cnt++;
        $display("FAIL %s[%0d]: got v=%0d e=%0d dir=%0b pos=%0d lock=%0b, want %0d %0d %0b %0d %0b",
                 name, i, obs_v, obs_e, direction, position, locked, ev, ee, ed, m_pos, el);
      end
    end
  endtask

  task automatic test_timeout();
    run_frame(350, 650);
    run_frame(350, 650);
    assert_cnt++;
    if (locked !== 1'b1 || position !== 7'd25 || direction !== 1'b1) begin
      fail_cnt++;
      $display("FAIL timeout_pre: got dir=%0b pos=%0d lock=%0b, want 1 25 1", direction, position, locked);
    end
    run_frame(350, 3000);
    assert_cnt++;
    if (obs_v !== 1 || obs_e !== 0 || direction !== 1'b0 || position !== 7'd0 || locked !== 1'b0) begin
      fail_cnt++;
      $display("FAIL timeout: got v=%0d e=%0d dir=%0b pos=%0d lock=%0b, want 1 0 0 0 0",
               obs_v, obs_e, direction, position, locked);
    end
  endtask

  task automatic test_reset_mid_pulse();
    int v0, e0;
    run_frame(320, 680);
    run_frame(320, 680);
    pwm_in = 1'b1;
    repeat (200) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    assert_cnt++;
    if (position !== 7'd0 || locked !== 1'b0 || direction !== 1'b0) begin
      fail_cnt++;
      $display("FAIL midreset_clear: got dir=%0b pos=%0d lock=%0b, want 0 0 0", direction, position, locked);
    end
    v0 = valid_seen; e0 = err_seen;
    rst = 1'b0;
    model_reset();
    repeat (150) @(negedge clk);
    pwm_in = 1'b0;
    repeat (600) @(negedge clk);
    assert_cnt++;
    if (valid_seen - v0 !== 0 || err_seen - e0 !== 0) begin
      fail_cnt++;
      $display("FAIL midreset_ignore: got valid=%0d err=%0d, want 0 0", valid_seen - v0, err_seen - e0);
    end
    run_frame(330, 670);
    assert_cnt++;
    if (obs_v !== 1 || obs_e !== 0 || direction !== 1'b1 || position !== 7'd15 || locked !== 1'b0) begin
      fail_cnt++;
      $display("FAIL midreset_next: got v=%0d e=%0d dir=%0b pos=%0d lock=%0b, want 1 0 1 15 0",
               obs_v, obs_e, direction, position, locked);
    end
  endtask

  initial begin
    test_reset();
    test_neutral_lock();
    test_boundaries();
    test_random();
    test_early_rise();
    test_bad_pulse(800, "out_of_range");
    test_bad_pulse(1200, "stuck_high");
    test_timeout();
    test_reset_mid_pulse();
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end
endmodule
